round_control: RTL and testbench

- Sequences play inside the GAME screen: serve, rally, point award, inter-point delay.
- Owns the score registers `points_1` and `points_2` that feed `screen_control`, and issues reset/enable to the ball datapath.
- Sits between the ball/collision logic (edge-exit pulses), the PS/2 keycode decoder and `screen_control`.

---
 rtl/round_control_pkg.sv | 26 ++
 rtl/round_control_frame_countdown.sv | 30 +++
 rtl/round_control.sv | 141 ++++++++++++++
 tb/tb_round_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/round_control_pkg.sv
// rtl/round_control_pkg.sv - shared game types and constants for the round sequencer
package round_control_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      PLAY   = 2'd2,
      SCORED = 2'd3
   } round_state_t;

   localparam logic [7:0] SERVE_KEY  = 8'h29;
   localparam logic [7:0] BREAK_CODE = 8'hF0;

   localparam logic [1:0] SCR_START = 2'b00;
   localparam logic [1:0] SCR_GAME  = 2'b01;
   localparam logic [1:0] SCR_P1    = 2'b11;
   localparam logic [1:0] SCR_P2    = 2'b10;

   localparam int TEN = 10;

   // A space make code, not the tail of a space break sequence.
   function automatic logic is_serve_key(input logic [15:0] keycode);
      return (keycode[15:8] != BREAK_CODE) && (keycode[7:0] == SERVE_KEY);
   endfunction

endpackage

// File: rtl/round_control_frame_countdown.sv
// rtl/round_control_frame_countdown.sv - loadable frame-tick down counter saturating at zero
module frame_countdown #(
   parameter int DLY_W = 7
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [DLY_W-1:0] i_load_value,
   input  logic             i_tick,
   output logic [DLY_W-1:0] o_count,
   output logic             o_zero
);

   logic [DLY_W-1:0] r_count;

   // A load in the same cycle as a tick takes priority.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/round_control.sv
// rtl/round_control.sv - serve/rally/score/delay sequencer owning both score registers
module round_control
   import round_control_pkg::*;
#(
   parameter int WIN_POINTS         = TEN,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int DLY_W              = 7
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_screen,
   input  logic [15:0] i_keycode,
   input  logic        i_frame_tick,
   input  logic        i_ball_out_left,
   input  logic        i_ball_out_right,
   output logic [4:0]  o_points_1,
   output logic [4:0]  o_points_2,
   output logic        o_ball_en,
   output logic        o_ball_rst,
   output logic        o_serve_dir,
   output logic        o_delay_active
);

   localparam logic [4:0]       WIN   = 5'(WIN_POINTS);
   localparam logic [DLY_W-1:0] DELAY = DLY_W'(SERVE_DELAY_FRAMES);

   round_state_t r_state, w_state_nxt;
   logic [4:0]   r_points_1, r_points_2, w_points_1_nxt, w_points_2_nxt;
   logic         r_ball_en, w_ball_en_nxt;
   logic         r_ball_rst, w_ball_rst_nxt;
   logic         r_serve_dir, w_serve_dir_nxt;
   logic         w_load;
   logic         w_zero;
   logic [DLY_W-1:0] w_count;

   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v >= WIN) ? WIN : v + 5'd1;
   endfunction

   frame_countdown #(.DLY_W(DLY_W)) u_countdown (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load       (w_load),
      .i_load_value (DELAY),
      .i_tick       (i_frame_tick && (r_state == WAIT)),
      .o_count      (w_count),
      .o_zero       (w_zero)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_points_1_nxt  = r_points_1;
      w_points_2_nxt  = r_points_2;
      w_ball_en_nxt   = r_ball_en;
      w_serve_dir_nxt = r_serve_dir;
      w_ball_rst_nxt  = 1'b0;
      w_load          = 1'b0;

      // Leaving the GAME screen aborts the round from any active state.
      if ((r_state != IDLE) && (i_screen != SCR_GAME)) begin
         w_state_nxt   = IDLE;
         w_ball_en_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_ball_en_nxt = 1'b0;
               if (i_screen == SCR_START) begin
                  w_points_1_nxt  = '0;
                  w_points_2_nxt  = '0;
                  w_serve_dir_nxt = 1'b0;
               end else if (i_screen == SCR_GAME) begin
                  w_state_nxt    = WAIT;
                  w_ball_rst_nxt = 1'b1;
                  w_load         = 1'b1;
               end
            end
            WAIT: begin
               w_ball_en_nxt = 1'b0;
               if (w_zero && is_serve_key(i_keycode)) begin
                  w_state_nxt   = PLAY;
                  w_ball_en_nxt = 1'b1;
               end
            end
            PLAY: begin
               w_ball_en_nxt = 1'b1;
               if (i_ball_out_left) begin
                  w_points_2_nxt  = sat_inc(r_points_2);
                  w_serve_dir_nxt = 1'b1;
                  w_ball_en_nxt   = 1'b0;
                  w_state_nxt     = SCORED;
               end else if (i_ball_out_right) begin
                  w_points_1_nxt  = sat_inc(r_points_1);
                  w_serve_dir_nxt = 1'b0;
                  w_ball_en_nxt   = 1'b0;
                  w_state_nxt     = SCORED;
               end
            end
            SCORED: begin
               w_ball_rst_nxt = 1'b1;
               w_ball_en_nxt  = 1'b0;
               if ((r_points_1 >= WIN) || (r_points_2 >= WIN)) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = WAIT;
                  w_load      = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_points_1  <= '0;
         r_points_2  <= '0;
         r_ball_en   <= 1'b0;
         r_ball_rst  <= 1'b0;
         r_serve_dir <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_points_1  <= w_points_1_nxt;
         r_points_2  <= w_points_2_nxt;
         r_ball_en   <= w_ball_en_nxt;
         r_ball_rst  <= w_ball_rst_nxt;
         r_serve_dir <= w_serve_dir_nxt;
      end
   end

   assign o_points_1     = r_points_1;
   assign o_points_2     = r_points_2;
   assign o_ball_en      = r_ball_en;
   assign o_ball_rst     = r_ball_rst;
   assign o_serve_dir    = r_serve_dir;
   assign o_delay_active = (r_state == WAIT);

   logic w_unused;
   assign w_unused = ^w_count;

endmodule

// File: tb/tb_round_control.sv
// tb/tb_round_control.sv - self-checking bench for round_control with a behavioural reference model
module tb_round_control;

   localparam int WIN = 10;
   localparam int SD  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  screen;
   logic [15:0] keycode;
   logic        frame_tick;
   logic        out_left;
   logic        out_right;
   logic [4:0]  points_1;
   logic [4:0]  points_2;
   logic        ball_en;
   logic        ball_rst;
   logic        serve_dir;
   logic        delay_active;

   int total = 0;
   int bad   = 0;

   // Reference model: rally phase as a name, scores as plain integers.
   string m_phase = "idle";
   int    m_left_frames = 0;
   int    m_p1 = 0, m_p2 = 0;
   bit    m_en = 0, m_rst_pulse = 0, m_dir = 0;

   always #5 clk = ~clk;

   round_control #(
      .WIN_POINTS         (WIN),
      .SERVE_DELAY_FRAMES (SD),
      .DLY_W              (7)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_screen         (screen),
      .i_keycode        (keycode),
      .i_frame_tick     (frame_tick),
      .i_ball_out_left  (out_left),
      .i_ball_out_right (out_right),
      .o_points_1       (points_1),
      .o_points_2       (points_2),
      .o_ball_en        (ball_en),
      .o_ball_rst       (ball_rst),
      .o_serve_dir      (serve_dir),
      .o_delay_active   (delay_active)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_step();
      bit key;
      key = (keycode[15:8] != 8'hF0) && (keycode[7:0] == 8'h29);
      m_rst_pulse = 0;
      if (rst) begin
         m_phase = "idle"; m_left_frames = 0;
         m_p1 = 0; m_p2 = 0; m_en = 0; m_dir = 0;
      end else if (m_phase != "idle" && screen != 2'b01) begin
         m_phase = "idle"; m_en = 0;
      end else if (m_phase == "idle") begin
         m_en = 0;
         if (screen == 2'b00) begin
            m_p1 = 0; m_p2 = 0; m_dir = 0;
         end else if (screen == 2'b01) begin
            m_phase = "serve_wait"; m_left_frames = SD; m_rst_pulse = 1;
         end
      end else if (m_phase == "serve_wait") begin
         if (m_left_frames == 0 && key) begin
            m_phase = "rally"; m_en = 1;
         end else if (frame_tick && m_left_frames > 0) begin
            m_left_frames--;
         end
      end else if (m_phase == "rally") begin
         if (out_left) begin
            m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1;
            m_dir = 1; m_en = 0; m_phase = "award";
         end else if (out_right) begin
            m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1;
            m_dir = 0; m_en = 0; m_phase = "award";
         end
      end else begin
         m_rst_pulse = 1;
         if (m_p1 >= WIN || m_p2 >= WIN) begin
            m_phase = "idle";
         end else begin
            m_phase = "serve_wait"; m_left_frames = SD;
         end
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("points_1", 32'(points_1), 32'(m_p1));
      chk("points_2", 32'(points_2), 32'(m_p2));
      chk("ball_en", 32'(ball_en), 32'(m_en));
      chk("ball_rst", 32'(ball_rst), 32'(m_rst_pulse));
      chk("serve_dir", 32'(serve_dir), 32'(m_dir));
      chk("delay_active", 32'(delay_active), 32'(m_phase == "serve_wait"));
   endtask

   task automatic go_play();
      keycode = 16'h0029;
      frame_tick = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (ball_en === 1'b1) break;
      end
      frame_tick = 1'b0;
      chk("serve_timeout", 32'(ball_en), 32'd1);
   endtask

   initial begin
      logic [15:0] keys [5];
      int r;
      keys[0] = 16'h0029; keys[1] = 16'hF029; keys[2] = 16'h0000;
      keys[3] = 16'h1229; keys[4] = 16'h0030;

      rst = 1'b1; screen = 2'b00; keycode = 16'h0000;
      frame_tick = 1'b0; out_left = 1'b0; out_right = 1'b0;
      cyc();
      chk("reset_p1", 32'(points_1), 32'd0);
      chk("reset_p2", 32'(points_2), 32'd0);
      chk("reset_en", 32'(ball_en), 32'd0);
      chk("reset_delay", 32'(delay_active), 32'd0);
      rst = 1'b0;

      // Enter GAME with space held; serve after three frame ticks.
      screen = 2'b01; keycode = 16'h0029;
      cyc();
      chk("enter_ball_rst", 32'(ball_rst), 32'd1);
      chk("enter_delay", 32'(delay_active), 32'd1);
      for (int i = 0; i < SD; i++) begin
         chk("wait_no_en", 32'(ball_en), 32'd0);
         frame_tick = 1'b1; cyc();
         frame_tick = 1'b0; cyc();
      end
      chk("serve_en", 32'(ball_en), 32'd1);
      keycode = 16'h0000;

      out_right = 1'b1; cyc(); out_right = 1'b0;
      chk("right_p1", 32'(points_1), 32'd1);
      chk("right_en", 32'(ball_en), 32'd0);
      chk("right_dir", 32'(serve_dir), 32'd0);
      cyc();
      chk("scored_ball_rst", 32'(ball_rst), 32'd1);

      go_play();
      out_left = 1'b1; out_right = 1'b1; cyc();
      out_left = 1'b0; out_right = 1'b0;
      chk("both_p2", 32'(points_2), 32'd1);
      chk("both_p1", 32'(points_1), 32'd1);
      chk("both_dir", 32'(serve_dir), 32'd1);

      for (int i = 0; i < 20 && m_p2 < 9; i++) begin
         go_play();
         out_left = 1'b1; cyc(); out_left = 1'b0;
      end
      chk("p2_nine", 32'(points_2), 32'd9);
      go_play();
      out_left = 1'b1; cyc(); out_left = 1'b0;
      chk("win_p2", 32'(points_2), 32'd10);
      keycode = 16'h0000;
      cyc();
      chk("win_en", 32'(ball_en), 32'd0);
      out_left = 1'b1; out_right = 1'b1;
      cyc(); cyc();
      out_left = 1'b0; out_right = 1'b0;
      chk("post_win_p2", 32'(points_2), 32'd10);
      chk("post_win_p1", 32'(points_1), 32'd1);

      screen = 2'b10; cyc(); cyc();
      chk("winner_hold_p2", 32'(points_2), 32'd10);
      chk("winner_hold_p1", 32'(points_1), 32'd1);
      screen = 2'b00; cyc();
      chk("start_clear_p1", 32'(points_1), 32'd0);
      chk("start_clear_p2", 32'(points_2), 32'd0);

      // Reset in the middle of a rally.
      screen = 2'b01;
      for (int i = 0; i < 4; i++) begin
         go_play();
         out_right = 1'b1; cyc(); out_right = 1'b0;
      end
      go_play();
      chk("mid_p1", 32'(points_1), 32'd4);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("midrst_p1", 32'(points_1), 32'd0);
      chk("midrst_en", 32'(ball_en), 32'd0);
      chk("midrst_dir", 32'(serve_dir), 32'd0);
      keycode = 16'h0000;
      cyc();
      out_left = 1'b1; cyc(); out_left = 1'b0;
      chk("wait_edge_p2", 32'(points_2), 32'd0);

      // Randomised soak against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         r = $urandom_range(0, 19);
         screen = (r == 16) ? 2'b00 : (r == 17) ? 2'b10 : (r == 18) ? 2'b11 : 2'b01;
         r = $urandom_range(0, 7);
         keycode = (r < 3) ? keys[0] : keys[r - 3];
         frame_tick = ($urandom_range(0, 2) == 0);
         out_left = ($urandom_range(0, 9) == 0);
         out_right = ($urandom_range(0, 9) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
